// File: rtl/ay_bus_pkg.sv
// Shared types and constants for the AY-3-8910 bus responder.
// Optional build macro: AY_REGMASK_EN. When it is defined, unused register bits
// are forced to 0 on commit (AY-3-8910). When it is undefined, all 8 bits are
// stored (YM2149).
package ay_bus_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REGS_W   = NUM_REGS * DATA_W;

    localparam logic [ADDR_W-1:0] R_ENV_SHAPE = 4'd13;

    typedef enum logic [1:0] {
        FN_IDLE,
        FN_LATCH,
        FN_WRITE,
        FN_READ
    } ay_bus_fn_t;

`ifdef AY_REGMASK_EN
    localparam logic [DATA_W-1:0] REG_MASK [NUM_REGS] = '{
        8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'h1F, 8'hFF,
        8'h1F, 8'h1F, 8'h1F, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF
    };
`else
    localparam logic [DATA_W-1:0] REG_MASK [NUM_REGS] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
    };
`endif

    // Map the BDIR/BC2/BC1 code to a bus function.
    function automatic ay_bus_fn_t decode_fn(input logic bdir, input logic bc2, input logic bc1);
        case ({bdir, bc2, bc1})
            3'b001, 3'b100, 3'b111: decode_fn = FN_LATCH;
            3'b110:                 decode_fn = FN_WRITE;
            3'b011:                 decode_fn = FN_READ;
            default:                decode_fn = FN_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ay_bus_sync.sv
// Bus synchroniser plus function stability filter.
// Ports: clk, rst_n (async active-low); bdir/bc2/bc1/a8/a9_n/da_in are the
// asynchronous bus lines. fn_c is the accepted function. stable_c means the
// current synchronised code matches the previous sample. a8_s/a9_n_s/da_s
// are the synchronised chip selects and data.
module ay_bus_sync
    import ay_bus_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bdir,
    input  logic              bc2,
    input  logic              bc1,
    input  logic              a8,
    input  logic              a9_n,
    input  logic [DATA_W-1:0] da_in,
    output ay_bus_fn_t        fn_c,
    output logic              stable_c,
    output logic              a8_s,
    output logic              a9_n_s,
    output logic [DATA_W-1:0] da_s
);

    localparam int unsigned BUS_W = DATA_W + 5;

    logic [BUS_W-1:0] sync_q [SYNC_STAGES];
    logic [2:0]       code_s;
    logic [2:0]       code_prev_q;
    ay_bus_fn_t       fn_q;

    assign {code_s, a8_s, a9_n_s, da_s} = sync_q[SYNC_STAGES-1];

    // Synchroniser chain and previous-sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            code_prev_q <= '0;
            fn_q        <= FN_IDLE;
        end else begin
            sync_q[0] <= {bdir, bc2, bc1, a8, a9_n, da_in};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            code_prev_q <= code_s;
            fn_q        <= fn_c;
        end
    end

    // Accept a new function only when two consecutive samples agree. This
    // rejects transient codes caused by skew between the bus lines.
    always_comb begin
        stable_c = (code_s == code_prev_q);
        fn_c     = fn_q;
        if (stable_c) begin
            fn_c = decode_fn(code_s[2], code_s[1], code_s[0]);
        end
    end

endmodule

// File: rtl/ay_bus_responder.sv
// Chip-side AY-3-8910 bus responder: decodes the bus function, latches the
// register address under chip select, commits writes into a 16x8 register
// file, and drives read data.
// Ports: clk, rst_n (async active-low); bdir/bc2/bc1/a8/a9_n/da_in are the
// bus inputs; da_out/da_oe are the read data and output enable; regs is the
// flat register file (reg n at [8n+7:8n]); wr_stb/wr_addr/env_restart carry
// the commit events.
// Optional build macro: AY_REGMASK_EN (see ay_bus_pkg).
module ay_bus_responder
    import ay_bus_pkg::*;
#(
    parameter logic [3:0]  CHIP_ADDR   = 4'h3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bdir,
    input  logic              bc2,
    input  logic              bc1,
    input  logic              a8,
    input  logic              a9_n,
    input  logic [DATA_W-1:0] da_in,
    output logic [DATA_W-1:0] da_out,
    output logic              da_oe,
    output logic [REGS_W-1:0] regs,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              env_restart
);

    ay_bus_fn_t        fn_c;
    logic              stable_c;
    logic              a8_s;
    logic              a9_n_s;
    logic [DATA_W-1:0] da_s;

    ay_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .bdir     (bdir),
        .bc2      (bc2),
        .bc1      (bc1),
        .a8       (a8),
        .a9_n     (a9_n),
        .da_in    (da_in),
        .fn_c     (fn_c),
        .stable_c (stable_c),
        .a8_s     (a8_s),
        .a9_n_s   (a9_n_s),
        .da_s     (da_s)
    );

    ay_bus_fn_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              selected_q, selected_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [REGS_W-1:0] regs_d;
    logic [DATA_W-1:0] da_out_d;
    logic              da_oe_d;
    logic              wr_stb_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic              env_restart_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FN_IDLE;
            addr_q      <= '0;
            selected_q  <= 1'b0;
            hold_q      <= '0;
            regs        <= '0;
            da_out      <= '0;
            da_oe       <= 1'b0;
            wr_stb      <= 1'b0;
            wr_addr     <= '0;
            env_restart <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            selected_q  <= selected_d;
            hold_q      <= hold_d;
            regs        <= regs_d;
            da_out      <= da_out_d;
            da_oe       <= da_oe_d;
            wr_stb      <= wr_stb_d;
            wr_addr     <= wr_addr_d;
            env_restart <= env_restart_d;
        end
    end

    // Next state and datapath updates.
    always_comb begin
        state_d       = fn_c;
        addr_d        = addr_q;
        selected_d    = selected_q;
        hold_d        = hold_q;
        regs_d        = regs;
        da_out_d      = '0;
        da_oe_d       = 1'b0;
        wr_stb_d      = 1'b0;
        wr_addr_d     = wr_addr;
        env_restart_d = 1'b0;

        // Address and data are captured only on stable samples, so the data
        // seen during a skew transient never reaches addr or hold.
        if (stable_c && (fn_c == FN_LATCH)) begin
            addr_d     = da_s[3:0];
            selected_d = (da_s[7:4] == CHIP_ADDR) && a8_s && !a9_n_s;
        end
        if (stable_c && (fn_c == FN_WRITE)) begin
            hold_d = da_s;
        end

        // Commit on the edge where the accepted function leaves WRITE.
        if ((state_q == FN_WRITE) && (fn_c != FN_WRITE) && selected_q) begin
            regs_d[{addr_q, 3'b000} +: DATA_W] = hold_q & REG_MASK[addr_q];
            wr_stb_d      = 1'b1;
            wr_addr_d     = addr_q;
            env_restart_d = (addr_q == R_ENV_SHAPE);
        end

        if ((fn_c == FN_READ) && selected_q) begin
            da_oe_d  = 1'b1;
            da_out_d = regs[{addr_q, 3'b000} +: DATA_W];
        end
    end

endmodule

// File: tb/tb_ay_bus_responder.sv
// Self-checking bench for ay_bus_responder: a write-vector table, a commit
// scoreboard, and hand sequences for read, deselect, skew glitch and reset.
module tb_ay_bus_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bdir, bc2, bc1, a8, a9_n;
    logic [7:0]   da_in;
    logic [7:0]   da_out;
    logic         da_oe;
    logic [127:0] regs;
    logic         wr_stb;
    logic [3:0]   wr_addr;
    logic         env_restart;

    int checks = 0;
    int errors = 0;

`ifdef AY_REGMASK_EN
    localparam bit MASKED = 1'b1;
`else
    localparam bit MASKED = 1'b0;
`endif

    ay_bus_responder #(
        .CHIP_ADDR   (4'h3),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bdir        (bdir),
        .bc2         (bc2),
        .bc1         (bc1),
        .a8          (a8),
        .a9_n        (a9_n),
        .da_in       (da_in),
        .da_out      (da_out),
        .da_oe       (da_oe),
        .regs        (regs),
        .wr_stb      (wr_stb),
        .wr_addr     (wr_addr),
        .env_restart (env_restart)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic       env;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_it;

    typedef struct {
        logic [7:0] latch_byte;
        logic [2:0] latch_fn;
        logic       a8v;
        logic       a9v;
        logic [7:0] wdata;
        logic       stb;
        logic [7:0] exp_masked;
        logic [7:0] exp_full;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold a bus function and data for n clocks; called on a falling edge.
    task automatic drive(input logic [2:0] f, input logic [7:0] d, input int n);
        {bdir, bc2, bc1} = f;
        da_in = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_latch(input logic [2:0] f, input logic [7:0] b);
        drive(3'b000, b, 2);
        drive(f, b, 6);
        drive(3'b000, b, 2);
    endtask

    task automatic do_write(input logic [7:0] d);
        drive(3'b000, d, 2);
        drive(3'b110, d, 6);
        drive(3'b000, d, 10);
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.env  = (a == 4'd13);
        sb_q.push_back(e);
    endtask

    // Commit monitor: every wr_stb must match the oldest expected commit.
    always @(negedge clk) begin
        if (wr_stb) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_wr_stb: got wr_addr %0h expected no commit", wr_addr);
            end else begin
                mon_it = sb_q.pop_front();
                check("wr_addr", 128'(wr_addr), 128'(mon_it.addr));
                check("commit_data", 128'(regs[8*mon_it.addr +: 8]), 128'(mon_it.data));
                check("env_restart", 128'(env_restart), 128'(mon_it.env));
            end
        end else if (env_restart) begin
            checks++;
            errors++;
            $display("FAIL env_without_stb: got env_restart 1 expected 0");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_v;
        logic       seen;

        vecs[0]  = '{8'h37, 3'b001, 1'b1, 1'b0, 8'hFF, 1'b1, 8'hFF, 8'hFF};
        vecs[1]  = '{8'h31, 3'b100, 1'b1, 1'b0, 8'hAB, 1'b1, 8'h0B, 8'hAB};
        vecs[2]  = '{8'h3D, 3'b111, 1'b1, 1'b0, 8'h0E, 1'b1, 8'h0E, 8'h0E};
        vecs[3]  = '{8'h3D, 3'b001, 1'b1, 1'b0, 8'h0E, 1'b1, 8'h0E, 8'h0E};
        vecs[4]  = '{8'h25, 3'b001, 1'b1, 1'b0, 8'h55, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{8'h3B, 3'b001, 1'b1, 1'b0, 8'h5A, 1'b1, 8'h5A, 8'h5A};
        vecs[6]  = '{8'h3F, 3'b100, 1'b1, 1'b0, 8'hC3, 1'b1, 8'hC3, 8'hC3};
        vecs[7]  = '{8'h36, 3'b001, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h1F, 8'hFF};
        vecs[8]  = '{8'h30, 3'b001, 1'b0, 1'b0, 8'h99, 1'b0, 8'h00, 8'h00};
        vecs[9]  = '{8'h30, 3'b001, 1'b1, 1'b1, 8'h88, 1'b0, 8'h00, 8'h00};
        vecs[10] = '{8'h30, 3'b111, 1'b1, 1'b0, 8'h12, 1'b1, 8'h12, 8'h12};

        rst_n = 1'b0;
        {bdir, bc2, bc1} = 3'b000;
        a8 = 1'b0;
        a9_n = 1'b1;
        da_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_regs", regs, 128'h0);
        check("reset_da_oe", 128'(da_oe), 128'h0);
        check("reset_da_out", 128'(da_out), 128'h0);
        check("reset_wr_stb", 128'(wr_stb), 128'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            a8   = vecs[i].a8v;
            a9_n = vecs[i].a9v;
            do_latch(vecs[i].latch_fn, vecs[i].latch_byte);
            exp_v = MASKED ? vecs[i].exp_masked : vecs[i].exp_full;
            if (vecs[i].stb) push(vecs[i].latch_byte[3:0], exp_v);
            do_write(vecs[i].wdata);
            check($sformatf("vec%0d_reg", i), 128'(regs[8*vecs[i].latch_byte[3:0] +: 8]), 128'(exp_v));
        end
        check("queue_drained_table", 128'(sb_q.size()), 128'h0);

        // Read back R11 through a matching latch.
        a8 = 1'b1;
        a9_n = 1'b0;
        do_latch(3'b001, 8'h3B);
        drive(3'b011, 8'h00, 1);
        for (int i = 0; i < 4 && !da_oe; i++) @(negedge clk);
        check("read_da_oe", 128'(da_oe), 128'h1);
        check("read_da_out", 128'(da_out), 128'h5A);
        drive(3'b000, 8'h00, 1);
        for (int i = 0; i < 6 && da_oe; i++) @(negedge clk);
        check("read_release", 128'(da_oe), 128'h0);

        // Wrong chip nibble deselects; a following read stays undriven.
        do_latch(3'b001, 8'h25);
        seen = 1'b0;
        {bdir, bc2, bc1} = 3'b011;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (da_oe) seen = 1'b1;
        end
        drive(3'b000, 8'h00, 4);
        check("deselected_read_oe", 128'(seen), 128'h0);
        check("deselected_r5", 128'(regs[8*5 +: 8]), 128'h0);

        // Skew transient 100 -> 111 (one sample) -> 110 must not relatch.
        do_latch(3'b100, 8'h32);
        drive(3'b100, 8'h32, 2);
        push(4'd2, 8'h77);
        drive(3'b111, 8'h77, 1);
        drive(3'b110, 8'h77, 6);
        drive(3'b000, 8'h77, 10);
        check("glitch_r2", 128'(regs[8*2 +: 8]), 128'h77);
        check("glitch_r7", 128'(regs[8*7 +: 8]), 128'hFF);

        // Reset in the middle of a WRITE discards the pending commit.
        do_latch(3'b001, 8'h30);
        drive(3'b000, 8'h12, 2);
        drive(3'b110, 8'h12, 6);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        drive(3'b000, 8'h00, 2);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("reset_write_regs", regs, 128'h0);
        check("reset_write_oe", 128'(da_oe), 128'h0);

        check("queue_drained_end", 128'(sb_q.size()), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
